reg_dump_uart_tx: RTL

- Reader and serial transmitter for the 8x8-bit register file that the single-cycle CPU datapath writes.
- On a start request it snapshots all eight register values and sends them out on UART_TXD as a framed 8N1 byte stream.
- Frame is: sync byte, R0..R7, XOR checksum.
- Sits beside the register file in the top level. Gives a host PC the board's architectural state, since the LCD only shows part of it.

---
 rtl/reg_dump_uart_tx_pkg.sv | 24 ++
 rtl/reg_dump_uart_tx_if.sv | 11 +
 rtl/reg_dump_uart_tx_byte.sv | 99 +++++++++
 rtl/reg_dump_uart_tx.sv | 81 ++++++++
 4 files changed

// File: rtl/reg_dump_uart_tx_pkg.sv
// Shared constants, FSM state type and checksum helper for the register-dump
// UART transmitter.
package reg_dump_uart_tx_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int FRAME_BYTES   = 10;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT
  } tx_state_e;

  // XOR of the eight register bytes; the sync byte is not part of it.
  function automatic logic [7:0] xor_bytes(input logic [63:0] d);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc ^ d[8*i +: 8];
    return acc;
  endfunction

endpackage

// File: rtl/reg_dump_uart_tx_if.sv
// Request / serial-output bundle between the host-side logic and the dumper.
interface reg_dump_uart_tx_if;
  logic        start;
  logic [63:0] reg_d;
  logic        txd;
  logic        busy;
  logic        done;

  modport master (output start, output reg_d, input txd, input busy, input done);
  modport slave  (input start, input reg_d, output txd, output busy, output done);
endinterface

// File: rtl/reg_dump_uart_tx_byte.sv
// 8N1 byte serializer: baud counter, shift register, start/stop framing.
// ready is high when a load on this edge will be accepted without a gap.
module uart_tx_byte
  import reg_dump_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign ready   = (state_q == IDLE) || ((state_q == STOP_BIT) && bit_end);
  assign txd     = txd_q;

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (load) begin
          state_d = START_BIT;
          shift_d = byte_in;
          txd_d   = 1'b0;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'(BITS_PER_BYTE - 1)) begin
            state_d = STOP_BIT;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            txd_d = shift_q[1];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (load) begin
            state_d = START_BIT;
            shift_d = byte_in;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Snapshots the 8x8 register file on start and streams sync, R0..R7 and an
// XOR checksum through the byte serializer, back to back.
module reg_dump_uart_tx
  import reg_dump_uart_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input logic              clk,
  input logic              rst,
  reg_dump_uart_tx_if.slave bus
);

  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] snap_q, snap_d;
  logic [7:0]  csum_q, csum_d;
  logic        load, ready, txd;
  logic [7:0]  byte_in;

  always_comb begin
    active_d = active_q;
    done_d   = 1'b0;
    idx_d    = idx_q;
    snap_d   = snap_q;
    csum_d   = csum_q;
    load     = 1'b0;
    byte_in  = SYNC_BYTE;
    if (!active_q) begin
      if (bus.start) begin
        load     = 1'b1;
        active_d = 1'b1;
        idx_d    = '0;
        snap_d   = bus.reg_d;
        csum_d   = xor_bytes(bus.reg_d);
      end
    end else if (ready) begin
      if (idx_q == 4'(FRAME_BYTES - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        // Byte idx+1 is R(idx) for idx 0..7, and the checksum after R7.
        load    = 1'b1;
        idx_d   = idx_q + 1'b1;
        byte_in = idx_q[3] ? csum_q : snap_q[{idx_q[2:0], 3'b000} +: 8];
      end
    end
  end

  // NOTE: the snapshot is a plain 64-bit register, so clearing it on reset is cheap and makes state deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      snap_q   <= '0;
      csum_q   <= '0;
    end else begin
      active_q <= active_d;
      done_q   <= done_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      csum_q   <= csum_d;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .byte_in(byte_in),
    .ready  (ready),
    .txd    (txd)
  );

  assign bus.txd  = txd;
  assign bus.busy = active_q;
  assign bus.done = done_q;

endmodule
